// File: rtl/flash_banked.sv
// Banked NOR-flash style word store: two-cycle read, clear-only program,
// multi-cycle sector erase, busy/done handshake and per-bank write protection.
module flash_banked #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BANK_BITS   = 4,
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned SECTOR_BITS = 12,
    parameter int unsigned PROG_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [BANK_BITS+ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_W-1:0]             cmd_wdata,
    input  logic [(1<<BANK_BITS)-1:0]     wp_mask,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rvalid,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int unsigned AW    = BANK_BITS + ADDR_BITS;
    localparam int unsigned WORDS = 1 << AW;
    localparam int unsigned PCW   = $clog2(PROG_CYCLES + 1);
    localparam int unsigned ECW   = SECTOR_BITS + 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, READ1, PROG, ERASE} state_t;

    state_t            state;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [PCW-1:0]    prog_cnt;
    logic [ECW-1:0]    erase_cnt;
    logic              rd_pend;
    logic              err_pend;
    logic [DATA_W-1:0] rd_word;

    // Cells hold the complement of the data so a zero-initialised array
    // reads as erased; program ORs in ~data and erase clears to zero.
    logic [DATA_W-1:0] cells [WORDS];

    logic              reject;
    logic [AW-1:0]     sector_base;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign cmd_ready = (state == IDLE) && !rst;

    always_comb begin
        reject = (cmd_op == OP_RSVD) ||
                 ((cmd_op != OP_READ) && wp_mask[cmd_addr[AW-1 -: BANK_BITS]]);
        sector_base = cmd_addr;
        sector_base[SECTOR_BITS-1:0] = '0;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = '0;
        if (state == PROG && prog_cnt == PCW'(PROG_CYCLES)) begin
            mem_we    = 1'b1;
            mem_wdata = rd_word | ~wdata_q;
        end else if (state == ERASE && !erase_cnt[SECTOR_BITS]) begin
            mem_we    = 1'b1;
            mem_waddr = {addr_q[AW-1:SECTOR_BITS], erase_cnt[SECTOR_BITS-1:0]};
        end
    end

    // Single synchronous read port tracks addr_q every cycle; program relies on
    // PROG_CYCLES >= 2 so rd_word already holds the old word at the write edge.
    always_ff @(posedge clk) begin
        if (mem_we)
            cells[mem_waddr] <= mem_wdata;
        rd_word <= cells[addr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            prog_cnt  <= '0;
            erase_cnt <= '0;
            rd_pend   <= 1'b0;
            err_pend  <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= err_pend;
            err_pend <= 1'b0;
            rvalid   <= rd_pend;
            rd_pend  <= 1'b0;
            if (rd_pend)
                rdata <= ~rd_word;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (reject) begin
                            err_pend <= 1'b1;
                        end else if (cmd_op == OP_READ) begin
                            addr_q <= cmd_addr;
                            state  <= READ1;
                        end else if (cmd_op == OP_PROG) begin
                            addr_q   <= cmd_addr;
                            wdata_q  <= cmd_wdata;
                            prog_cnt <= PCW'(1);
                            busy     <= 1'b1;
                            state    <= PROG;
                        end else if (cmd_op == OP_ERASE) begin
                            addr_q    <= sector_base;
                            erase_cnt <= '0;
                            busy      <= 1'b1;
                            state     <= ERASE;
                        end
                    end
                end
                READ1: begin
                    rd_pend <= 1'b1;
                    state   <= IDLE;
                end
                PROG: begin
                    if (prog_cnt == PCW'(PROG_CYCLES)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        prog_cnt <= prog_cnt + PCW'(1);
                    end
                end
                ERASE: begin
                    if (erase_cnt[SECTOR_BITS]) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        erase_cnt <= erase_cnt + ECW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_banked.sv
// Scoreboarded bench for flash_banked: directed scenarios plus random command
// stream against an array-level model of flash semantics.
`timescale 1ns/1ps
module tb_flash_banked;
    localparam int DW = 8, BB = 2, AB = 8, SB = 4, PC = 3;
    localparam int AW = BB + AB;
    localparam int NW = 1 << AW;
    localparam int SW = 1 << SB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    wp_mask = '0;
    logic [DW-1:0] rdata;
    logic          rvalid, busy, done, err;

    always #5 clk = ~clk;

    flash_banked #(
        .DATA_W(DW), .BANK_BITS(BB), .ADDR_BITS(AB),
        .SECTOR_BITS(SB), .PROG_CYCLES(PC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .wp_mask(wp_mask), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .done(done), .err(err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected output events: kind 0 = rvalid, 1 = done, 2 = err.
    typedef struct { int kind; logic [7:0] data; int at; } ev_t;
    ev_t q[$];
    logic [7:0] model [NW];
    int busy_lo = 0, busy_hi = 0, free_at = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int n, input logic [1:0] op, input logic [AW-1:0] addr,
                                input logic [7:0] wd, input logic [3:0] wp);
        int bank, base;
        bank = int'(addr) / (1 << AB);
        if (op == 2'b11 || (op != 2'b00 && wp[bank])) begin
            q.push_back('{kind: 2, data: 8'h00, at: n + 1});
            free_at = n + 1;
        end else if (op == 2'b00) begin
            q.push_back('{kind: 0, data: model[addr], at: n + 2});
            free_at = n + 2;
        end else if (op == 2'b01) begin
            model[addr] = model[addr] & wd;
            q.push_back('{kind: 1, data: 8'h00, at: n + PC});
            busy_lo = n; busy_hi = n + PC; free_at = n + PC + 1;
        end else begin
            base = (int'(addr) / SW) * SW;
            for (int i = 0; i < SW; i++) model[base + i] = 8'hFF;
            q.push_back('{kind: 1, data: 8'h00, at: n + SW + 1});
            busy_lo = n; busy_hi = n + SW + 1; free_at = n + SW + 2;
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] wd,
                         input logic [3:0] wp, output int n);
        bit got;
        got = 0;
        n = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; wp_mask = wp;
        for (int k = 0; k < 100 && !got; k++) begin
            check("cmd_ready", cmd_ready, (cyc + 1 >= free_at));
            if (cmd_ready) begin
                got = 1;
                n = cyc + 1;
                model_accept(n, op, addr, wd, wp);
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d addr 0x%0h never accepted", op, addr);
        end
    endtask

    task automatic wait_idle();
        cmd_valid = 1'b0;
        for (int k = 0; k < 200 && (q.size() > 0 || cyc + 1 < free_at); k++) @(negedge clk);
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d events still pending", q.size());
        end
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        int n;
        issue(2'b00, addr, 8'($urandom), 4'($urandom), n);
    endtask

    int mkind;
    ev_t me;
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
            while (q.size() > 0 && q[0].at < cyc) begin
                checks++; errors++;
                $display("FAIL missed_event: kind %0d due at cycle %0d not seen by %0d",
                         q[0].kind, q[0].at, cyc);
                void'(q.pop_front());
            end
            if (rvalid || done || err) begin
                mkind = rvalid ? 0 : (done ? 1 : 2);
                check("exclusive_pulse", int'(rvalid) + int'(done) + int'(err), 1);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d", mkind, cyc);
                end else begin
                    me = q.pop_front();
                    check("event_kind", mkind, me.kind);
                    check("event_cycle", cyc, me.at);
                    if (me.kind == 0) check("rdata", rdata, me.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n1, n2, r;
        logic [1:0] op;
        logic [AW-1:0] a;
        for (int i = 0; i < NW; i++) model[i] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("ready_in_reset", cmd_ready, 0);
        check("busy_in_reset", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", cmd_ready, 1);
        check("reset_rvalid", rvalid, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_rdata", rdata, 0);

        // 1: read of erased array
        rd(10'h305);
        wait_idle();

        // 2: program twice, bits only clear
        issue(2'b01, 10'h1A5, 8'hF0, 4'h0, n);
        wait_idle();
        issue(2'b01, 10'h1A5, 8'h3C, 4'h0, n);
        wait_idle();
        rd(10'h1A5);
        check("model_1a5", model[10'h1A5], 8'h30);
        wait_idle();

        // 3: last sector of bank 0, and last sector of last bank
        for (int i = 10'h0F0; i <= 10'h100; i++) issue(2'b01, 10'(i), 8'h00, 4'h0, n);
        issue(2'b01, 10'h000, 8'h00, 4'h0, n);
        issue(2'b01, 10'h3F3, 8'h00, 4'h0, n);
        issue(2'b10, 10'h0F7, 8'h00, 4'h0, n);
        issue(2'b10, 10'h3F5, 8'h00, 4'h0, n);
        for (int i = 10'h0F0; i <= 10'h100; i++) rd(10'(i));
        rd(10'h000);
        rd(10'h3F3);
        rd(10'h3FF);
        wait_idle();

        // 4: write protection and reserved op
        issue(2'b01, 10'h2A0, 8'h00, 4'b0100, n);
        issue(2'b10, 10'h2A0, 8'h00, 4'b0100, n);
        issue(2'b11, 10'h123, 8'h00, 4'b0000, n);
        rd(10'h2A0);
        wait_idle();

        // 5: reset during erase
        for (int i = 10'h040; i <= 10'h04F; i++) issue(2'b01, 10'(i), 8'h00, 4'h0, n);
        wait_idle();
        issue(2'b10, 10'h040, 8'h00, 4'h0, n);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rvalid", rvalid, 0);
        check("abort_err", err, 0);
        check("abort_rdata", rdata, 0);
        check("abort_ready", cmd_ready, 0);
        q.delete();
        busy_lo = 0; busy_hi = 0; free_at = 0;
        for (int i = 10'h045; i <= 10'h04F; i++) model[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 10'h040; i <= 10'h04F; i++) rd(10'(i));
        wait_idle();

        // 6: back-to-back programs with valid held high
        issue(2'b01, 10'h333, 8'h5A, 4'h0, n1);
        issue(2'b01, 10'h334, 8'hA5, 4'h0, n2);
        check("b2b_accept_gap", n2 - n1, PC + 1);
        wait_idle();
        rd(10'h333);
        rd(10'h334);
        wait_idle();

        // Random stream; wp_mask also changes while earlier ops are busy
        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 99);
            op = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 88) ? 2'b10 : 2'b11;
            a = {2'($urandom), 8'($urandom_range(0, 47))};
            issue(op, a, 8'($urandom), 4'($urandom) & 4'($urandom), n);
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        for (int i = 0; i < 16; i++) rd({2'($urandom), 8'($urandom_range(0, 47))});
        wait_idle();
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
